// File: rtl/pam_mul_sched.sv
// Four-way round-robin front end sharing one 8x8 PAM approximate multiplier.
// Define PAM_EXACT_EN to build the exact x*y product instead of the approximation.
module pam_mul_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  output logic [3:0]  req_ready,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_z,
  output logic [1:0]  out_id
);

  localparam int NREQ = 4;

  logic [1:0]  r_ptr;
  logic        r_s1_valid;
  logic [7:0]  r_s1_x;
  logic [7:0]  r_s1_y;
  logic [1:0]  r_s1_id;
  logic        r_out_valid;
  logic [15:0] r_out_z;
  logic [1:0]  r_out_id;

  logic        w_s2_load;
  logic        w_s1_load;
  logic        w_fire;
  logic [1:0]  w_win;
  logic [7:0]  w_lane_x [NREQ];
  logic [7:0]  w_lane_y [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign w_lane_x[gi] = req_x[8*gi +: 8];
      assign w_lane_y[gi] = req_y[8*gi +: 8];
    end
  endgenerate

  function automatic logic [15:0] pam_f(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] t0, t1, t2, t3;
    t0 = ({8'd0, y} * {12'd0, x[7:4]}) << 4;
    t1 = {7'd0, (y[6] & x[2]) | (y[5] & x[3]), 8'd0};
    t2 = {5'd0, (y[7] & x[2]) | (y[6] & x[3]), 10'd0};
    t3 = {5'd0, y[7] & x[3], 10'd0};
    return t0 + t1 + t2 + t3;
  endfunction

  function automatic logic [15:0] mul_f(input logic [7:0] x, input logic [7:0] y);
`ifdef PAM_EXACT_EN
    return {8'd0, x} * {8'd0, y};
`else
    return pam_f(x, y);
`endif
  endfunction

  assign w_s2_load = !r_out_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;

  // Scan from the highest offset down so the last hit is the first one after ptr.
  always_comb begin
    w_win = r_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[r_ptr + 2'(k)]) begin
        w_win = r_ptr + 2'(k);
      end
    end
  end

  assign w_fire    = rst_n && w_s1_load && (|req_valid);
  assign req_ready = w_fire ? (4'b0001 << w_win) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_id    <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= w_fire;
      if (w_fire) begin
        r_s1_x  <= w_lane_x[w_win];
        r_s1_y  <= w_lane_y[w_win];
        r_s1_id <= w_win;
        r_ptr   <= w_win + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_z     <= '0;
      r_out_id    <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      r_out_z     <= mul_f(r_s1_x, r_s1_y);
      r_out_id    <= r_s1_id;
    end
  end

  assign out_valid = r_out_valid;
  assign out_z     = r_out_z;
  assign out_id    = r_out_id;

endmodule

// File: tb/tb_pam_mul_sched.sv
// Directed bench for pam_mul_sched: reset, values, round-robin, backpressure,
// pointer hold and asynchronous reset with a full pipeline.
module tb_pam_mul_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_z;
  logic [1:0]  out_id;

  int checks = 0;
  int errors = 0;

`ifdef PAM_EXACT_EN
  localparam logic [15:0] Z_FF_FF = 16'hFE01;
  localparam logic [15:0] Z_0F_FF = 16'h0EF1;
`else
  localparam logic [15:0] Z_FF_FF = 16'hF810;
  localparam logic [15:0] Z_0F_FF = 16'h0900;
`endif

  // Lane operands for round-robin; products identical in both builds.
  logic [7:0]  rr_x [4];
  logic [7:0]  rr_y [4];
  logic [15:0] rr_z [4];

  pam_mul_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] x, input logic [7:0] y);
    req_x[8*i +: 8] = x;
    req_y[8*i +: 8] = y;
  endtask

  initial begin
    rr_x[0] = 8'h30; rr_y[0] = 8'h05; rr_z[0] = 16'h00F0;
    rr_x[1] = 8'h00; rr_y[1] = 8'h55; rr_z[1] = 16'h0000;
    rr_x[2] = 8'h10; rr_y[2] = 8'h03; rr_z[2] = 16'h0030;
    rr_x[3] = 8'h20; rr_y[3] = 8'h02; rr_z[3] = 16'h0040;

    rst_n = 1'b0; req_valid = 4'hF; req_x = '0; req_y = '0; out_ready = 1'b1;
    #12;
    chk("rst_ready", 16'(req_ready), 16'h0);
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_z", out_z, 16'h0);
    chk("rst_id", 16'(out_id), 16'h0);
    req_valid = 4'h0;
    rst_n = 1'b1;
    step();

    // Single request from requester 2
    set_lane(2, 8'hFF, 8'hFF);
    req_valid = 4'b0100;
    #1 chk("t1_ready", 16'(req_ready), 16'h4);
    step();
    req_valid = 4'h0;
    chk("t1_lat_valid", 16'(out_valid), 16'h0);
    step();
    chk("t1_valid", 16'(out_valid), 16'h1);
    chk("t1_id", 16'(out_id), 16'h2);
    chk("t1_z", out_z, Z_FF_FF);

    // Value checks from requester 3 (leaves ptr at 0)
    set_lane(3, 8'h0F, 8'hFF);
    req_valid = 4'b1000;
    #1 chk("v1_ready", 16'(req_ready), 16'h8);
    step();
    req_valid = 4'h0;
    step();
    chk("v1_z", out_z, Z_0F_FF);
    chk("v1_id", 16'(out_id), 16'h3);
    set_lane(3, 8'h30, 8'h05);
    req_valid = 4'b1000;
    step();
    req_valid = 4'h0;
    step();
    chk("v2_z", out_z, 16'h00F0);
    step();
    chk("v_idle", 16'(out_valid), 16'h0);

    // Round-robin with all four valid
    for (int i = 0; i < 4; i++) set_lane(i, rr_x[i], rr_y[i]);
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1 chk($sformatf("rr_ready%0d", c), 16'(req_ready), 16'(4'b0001 << (c % 4)));
      step();
      if (c >= 1) begin
        chk($sformatf("rr_valid%0d", c), 16'(out_valid), 16'h1);
        chk($sformatf("rr_id%0d", c), 16'(out_id), 16'((c - 1) % 4));
        chk($sformatf("rr_z%0d", c), out_z, rr_z[(c - 1) % 4]);
      end
    end
    req_valid = 4'h0;
    step();
    chk("rr_last_id", 16'(out_id), 16'h3);
    chk("rr_last_z", out_z, 16'h0040);
    step();
    chk("rr_drain", 16'(out_valid), 16'h0);

    // Backpressure stream from requester 1 (y=1 so z=x)
    set_lane(1, 8'h10, 8'h01);
    req_valid = 4'b0010;
    #1 chk("bp_a_ready", 16'(req_ready), 16'h2);
    step();
    req_valid = 4'h0;
    step();
    chk("bp_b_z", out_z, 16'h0010);
    chk("bp_b_id", 16'(out_id), 16'h1);
    out_ready = 1'b0;
    req_valid = 4'b0010;
    set_lane(1, 8'h20, 8'h01);
    #1 chk("bp_fill_ready", 16'(req_ready), 16'h2);
    step();
    chk("bp_c_z", out_z, 16'h0010);
    chk("bp_c_valid", 16'(out_valid), 16'h1);
    set_lane(1, 8'h30, 8'h01);
    #1 chk("bp_d_ready", 16'(req_ready), 16'h0);
    step();
    chk("bp_d_z", out_z, 16'h0010);
    chk("bp_d_id", 16'(out_id), 16'h1);
    #1 chk("bp_e_ready", 16'(req_ready), 16'h0);
    step();
    chk("bp_e_z", out_z, 16'h0010);
    out_ready = 1'b1;
    #1 chk("bp_f_ready", 16'(req_ready), 16'h2);
    step();
    chk("bp_f_z", out_z, 16'h0020);
    req_valid = 4'h0;
    step();
    chk("bp_g_valid", 16'(out_valid), 16'h1);
    chk("bp_g_z", out_z, 16'h0030);
    step();
    chk("bp_drain", 16'(out_valid), 16'h0);

    // Pointer hold: 3 fires, two idle cycles, then 0 and 3 both valid
    for (int i = 0; i < 4; i++) set_lane(i, rr_x[i], rr_y[i]);
    req_valid = 4'b1000;
    #1 chk("ph_ready3", 16'(req_ready), 16'h8);
    step();
    req_valid = 4'h0;
    step();
    step();
    req_valid = 4'b1001;
    #1 chk("ph_ready0", 16'(req_ready), 16'h1);
    step();
    #1 chk("ph_ready3b", 16'(req_ready), 16'h8);
    step();
    req_valid = 4'h0;
    chk("ph_id0", 16'(out_id), 16'h0);
    chk("ph_z0", out_z, 16'h00F0);
    step();
    chk("ph_id3", 16'(out_id), 16'h3);
    chk("ph_z3", out_z, 16'h0040);

    // Asynchronous reset with S1 and S2 full
    out_ready = 1'b0;
    req_valid = 4'hF;
    step();
    step();
    chk("ar_full_valid", 16'(out_valid), 16'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", 16'(out_valid), 16'h0);
    chk("ar_z", out_z, 16'h0);
    chk("ar_ready", 16'(req_ready), 16'h0);
    #2;
    req_valid = 4'h0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("ar_stale%0d", c), 16'(out_valid), 16'h0);
    end
    req_valid = 4'hF;
    #1 chk("ar_ptr_ready", 16'(req_ready), 16'h1);
    step();
    req_valid = 4'h0;
    step();
    chk("ar_post_id", 16'(out_id), 16'h0);
    chk("ar_post_z", out_z, 16'h00F0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
